// File: rtl/sort_sequencer.sv
// sort_sequencer: host-side controller for the 8-entry selection-sort circuit.
// Loads 8 bytes from a valid/ready input stream into the sorter memory, pulses
// the sorter start, waits out the ready handshake (with a watchdog), then reads
// the sorted bytes back and emits them as a valid/ready output stream.
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset (shared with sorter)
//   in_valid/in_ready/in_data host input byte stream
//   out_valid/out_ready/out_data sorted output byte stream
//   busy                      job in progress (bytes loaded or not in LOAD)
//   done                      one-cycle pulse on the final output handshake
//   err                       sticky watchdog timeout flag (cleared by nrst only)
//   sort_cycles               wait-cycle count of the last completed sort
//   s_start/s_wr/s_addr/s_datain  drive the sorter
//   s_dataout/s_ready         from the sorter (s_ready is registered there)
module sort_sequencer #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int CW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] sort_cycles,
  output logic          s_start,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_datain,
  input  logic [DW-1:0] s_dataout,
  input  logic          s_ready
);

  typedef enum logic [2:0] {
    LOAD, START, WAIT_BUSY, WAIT_DONE, RD_ISSUE, RD_CAP, RD_HOLD
  } state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] k, k_nxt;
  logic [CW-1:0] cyc, cyc_nxt, cyc_inc;
  logic [CW-1:0] sort_cycles_nxt;
  logic [DW-1:0] out_data_nxt;
  logic          out_valid_nxt;
  logic          err_nxt;
  logic          tmo;

  // Saturating wait-cycle counter; the watchdog fires on the cycle whose
  // increment would reach TIMEOUT.
  assign cyc_inc = (cyc == '1) ? cyc : cyc + 1'b1;
  assign tmo     = (int'(cyc) + 1) >= TIMEOUT;
  assign busy    = (cnt != '0) || (state != LOAD);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= LOAD;
      cnt         <= '0;
      k           <= '0;
      cyc         <= '0;
      sort_cycles <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      k           <= k_nxt;
      cyc         <= cyc_nxt;
      sort_cycles <= sort_cycles_nxt;
      out_valid   <= out_valid_nxt;
      out_data    <= out_data_nxt;
      err         <= err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    k_nxt           = k;
    cyc_nxt         = cyc;
    sort_cycles_nxt = sort_cycles;
    out_valid_nxt   = out_valid;
    out_data_nxt    = out_data;
    err_nxt         = err;
    in_ready        = 1'b0;
    s_start         = 1'b0;
    s_wr            = 1'b0;
    s_addr          = '0;
    s_datain        = '0;
    done            = 1'b0;

    case (state)
      LOAD: begin
        in_ready = s_ready;
        if (in_valid && s_ready) begin
          s_wr     = 1'b1;
          s_addr   = cnt;
          s_datain = in_data;
          cnt_nxt  = cnt + 1'b1;
          if (cnt == LAST) state_nxt = START;
        end
      end
      START: begin
        s_start   = 1'b1;
        cyc_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      // s_ready is still high from before the start edge on the first cycle
      // here, so only its falling edge moves us on.
      WAIT_BUSY: begin
        cyc_nxt = cyc_inc;
        if (tmo) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end else if (!s_ready) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (s_ready) begin
          sort_cycles_nxt = cyc;
          k_nxt           = '0;
          state_nxt       = RD_ISSUE;
        end else begin
          cyc_nxt = cyc_inc;
          if (tmo) begin
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = LOAD;
          end
        end
      end
      RD_ISSUE: begin
        s_addr    = k;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        s_addr        = k;
        out_data_nxt  = s_dataout;
        out_valid_nxt = 1'b1;
        state_nxt     = RD_HOLD;
      end
      RD_HOLD: begin
        s_addr = k;
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          if (k == LAST) begin
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            k_nxt     = k + 1'b1;
            state_nxt = RD_ISSUE;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Testbench for sort_sequencer with a behavioural stand-in for the sorter
// circuit (8x8 sync memory, registered ready, fixed sort latency, optional
// stuck mode that never completes).
module tb_sort_sequencer;

  localparam int DW = 8, AW = 3, CW = 8, TIMEOUT = 200, SORT_LEN = 20;

  typedef logic [7:0] blk_t [8];

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data, s_datain, s_dataout;
  logic          busy, done, err, s_start, s_wr, s_ready;
  logic [CW-1:0] sort_cycles;
  logic [AW-1:0] s_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sort_sequencer #(.DW(DW), .AW(AW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .sort_cycles(sort_cycles),
    .s_start(s_start), .s_wr(s_wr), .s_addr(s_addr), .s_datain(s_datain),
    .s_dataout(s_dataout), .s_ready(s_ready)
  );

  // ---------------- sorter stand-in ----------------
  blk_t mem;
  logic m_sorting;
  int   m_timer;
  bit   stuck = 1'b0;

  function automatic blk_t sorted_of(input blk_t a);
    blk_t t = a;
    logic [7:0] sw;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (t[j] > t[j+1]) begin sw = t[j]; t[j] = t[j+1]; t[j+1] = sw; end
    return t;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_sorting <= 1'b0;
      m_timer   <= 0;
      s_ready   <= 1'b0;
      s_dataout <= '0;
    end else begin
      s_ready <= !m_sorting;
      if (!m_sorting) begin
        if (s_start) begin m_sorting <= 1'b1; m_timer <= SORT_LEN; end
        else if (s_wr) mem[s_addr] <= s_datain;
      end else if (!stuck) begin
        if (m_timer == 0) begin mem <= sorted_of(mem); m_sorting <= 1'b0; end
        else m_timer <= m_timer - 1;
      end
      if (!s_wr) s_dataout <= mem[s_addr];
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0]    obs_q[$];
  bit            obs_done[$];
  logic [AW-1:0] wr_log[$];
  int n_start = 0, n_done = 0, n_ov = 0;

  always @(negedge clk) begin
    if (nrst) begin
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        obs_done.push_back(done);
      end
      if (done)      n_done++;
      if (s_start)   n_start++;
      if (s_wr)      wr_log.push_back(s_addr);
      if (out_valid) n_ov++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard / stimulus ----------------
  logic [7:0] exp_q[$];

  task automatic load_job(input blk_t d, input blk_t e, input bit push, input int max_gap);
    bit hs;
    int guard;
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d[i];
      guard    = 0;
      do begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1; guard++;
      end while (!hs && guard < 1000);
      if (!hs) begin
        n_checks++; n_fail++;
        $display("FAIL load_handshake[%0d]: in_ready never asserted within %0d cycles", i, guard);
      end
      in_valid = 1'b0;
      in_data  = '0;
    end
    if (push) for (int i = 0; i < 8; i++) exp_q.push_back(e[i]);
  endtask

  task automatic wait_obs(input int n, input string tag);
    int guard = 0;
    while (obs_q.size() < n && guard < 2000) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (obs_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_wait: got %0d outputs, required %0d", tag, obs_q.size(), n);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, done, err, sort_cycles, s_start, s_wr, s_addr, s_datain, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ov=%b od=%0d done=%b err=%b sc=%0d st=%b wr=%b a=%0d di=%0d busy=%b required all 0",
               out_valid, out_data, done, err, sort_cycles, s_start, s_wr, s_addr, s_datain, busy);
    end
    @(posedge clk); #1 nrst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_sorted_basic;
    blk_t d = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
    blk_t e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    int base = obs_q.size(), st0 = n_start, dn0 = n_done;
    logic [7:0] ex;
    load_job(d, e, 1'b1, 0);
    wait_obs(base + 8, "basic");
    for (int i = 0; i < 8; i++) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %0d required %0d", i, obs_q[base+i], ex);
      end
      n_checks++;
      if (obs_done[base+i] !== (i == 7)) begin
        n_fail++; $display("FAIL basic_done[%0d]: got %b required %b", i, obs_done[base+i], (i == 7));
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0", busy); end
    n_checks++;
    if (n_done - dn0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", n_done - dn0); end
    n_checks++;
    if (n_start - st0 != 1) begin n_fail++; $display("FAIL basic_start_cycles: got %0d required 1", n_start - st0); end
    n_checks++;
    if (sort_cycles == 0 || int'(sort_cycles) >= TIMEOUT) begin
      n_fail++; $display("FAIL basic_sort_cycles: got %0d required 1..%0d", sort_cycles, TIMEOUT - 1);
    end
  endtask

  task automatic test_gaps_dups;
    blk_t d = '{8'd9, 8'd9, 8'd1, 8'd200, 8'd1, 8'd0, 8'd255, 8'd9};
    blk_t e = '{8'd0, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd200, 8'd255};
    int base = obs_q.size(), wb = wr_log.size();
    logic [7:0] ex;
    load_job(d, e, 1'b1, 3);
    wait_obs(base + 8, "gaps");
    n_checks++;
    if (wr_log.size() - wb != 8) begin n_fail++; $display("FAIL gaps_write_count: got %0d required 8", wr_log.size() - wb); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (wr_log[wb+i] !== AW'(i)) begin n_fail++; $display("FAIL gaps_addr[%0d]: got %0d required %0d", i, wr_log[wb+i], i); end
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin n_fail++; $display("FAIL gaps_data[%0d]: got %0d required %0d", i, obs_q[base+i], ex); end
    end
  endtask

  task automatic test_backpressure;
    blk_t d = '{8'd40, 8'd10, 8'd30, 8'd80, 8'd20, 8'd70, 8'd60, 8'd50};
    blk_t e = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    int base = obs_q.size(), st0 = n_start, guard;
    logic [7:0] ex;
    load_job(d, e, 1'b1, 0);
    wait_obs(base + 3, "stall_pre");
    out_ready = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!out_valid && guard < 20);
    for (int j = 0; j < 10; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd40 || s_addr !== 3'd3 || s_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: ov=%b od=%0d addr=%0d wr=%b required ov=1 od=40 addr=3 wr=0",
                 j, out_valid, out_data, s_addr, s_wr);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (s_addr !== 3'd4) begin n_fail++; $display("FAIL stall_next_addr: got %0d required 4", s_addr); end
    wait_obs(base + 8, "stall");
    for (int i = 0; i < 8; i++) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d required %0d", i, obs_q[base+i], ex); end
    end
    n_checks++;
    if (n_start - st0 != 1) begin n_fail++; $display("FAIL stall_start_cycles: got %0d required 1", n_start - st0); end
  endtask

  task automatic test_timeout;
    blk_t d  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    blk_t d2 = '{8'd100, 8'd7, 8'd55, 8'd7, 8'd3, 8'd250, 8'd0, 8'd128};
    blk_t e2 = '{8'd0, 8'd3, 8'd7, 8'd7, 8'd55, 8'd100, 8'd128, 8'd250};
    int ov0 = n_ov, base;
    logic [7:0] ex;
    stuck = 1'b1;
    load_job(d, d, 1'b0, 0);
    @(negedge clk);
    n_checks++;
    if (s_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b required 1", s_start); end
    for (int n = 1; n <= TIMEOUT + 1; n++) begin
      @(negedge clk);
      if (n == TIMEOUT) begin
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: err=%b at wait cycle %0d required 0", err, n); end
      end
    end
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL tmo_fire: err=%b busy=%b in_ready=%b required 1 0 0", err, busy, in_ready);
    end
    n_checks++;
    if (n_ov != ov0) begin n_fail++; $display("FAIL tmo_no_output: out_valid cycles %0d required 0", n_ov - ov0); end
    stuck = 1'b0;
    base = obs_q.size();
    load_job(d2, e2, 1'b1, 1);
    wait_obs(base + 8, "tmo_next");
    for (int i = 0; i < 8; i++) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin n_fail++; $display("FAIL tmo_next_data[%0d]: got %0d required %0d", i, obs_q[base+i], ex); end
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: err=%b required 1", err); end
    @(posedge clk); #1 nrst = 1'b0; #1;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: err=%b required 0", err); end
    @(posedge clk); #1 nrst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_job;
    blk_t da = '{8'd1, 8'd9, 8'd2, 8'd8, 8'd3, 8'd7, 8'd4, 8'd6};
    blk_t d5 = '{8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10};
    blk_t e5 = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
    blk_t d6 = '{8'd8, 8'd6, 8'd4, 8'd2, 8'd1, 8'd3, 8'd5, 8'd7};
    blk_t e6 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    blk_t d7 = '{8'd255, 8'd254, 8'd0, 8'd1, 8'd128, 8'd127, 8'd2, 8'd3};
    blk_t e7 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd254, 8'd255};
    int base, ov0, guard;
    logic [7:0] ex;
    // reset while waiting for the sort to finish
    load_job(da, da, 1'b0, 0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 nrst = 1'b0; #1;
    n_checks++;
    if ({out_valid, out_data, done, err, sort_cycles, s_start, s_wr, s_addr, s_datain, busy} !== '0) begin
      n_fail++; $display("FAIL rst_wait_values: ov=%b od=%0d sc=%0d busy=%b required all 0", out_valid, out_data, sort_cycles, busy);
    end
    repeat (2) @(posedge clk); #1 nrst = 1'b1;
    base = obs_q.size(); ov0 = n_ov;
    repeat (40) @(posedge clk);
    n_checks++;
    if (obs_q.size() != base || n_ov != ov0) begin
      n_fail++; $display("FAIL rst_wait_no_output: outputs %0d valid cycles %0d required 0", obs_q.size() - base, n_ov - ov0);
    end
    load_job(d5, e5, 1'b1, 0);
    wait_obs(base + 8, "rst_wait_fresh");
    for (int i = 0; i < 8; i++) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin n_fail++; $display("FAIL rst_wait_fresh[%0d]: got %0d required %0d", i, obs_q[base+i], ex); end
    end
    // reset while holding output byte k=5
    base = obs_q.size();
    load_job(d6, e6, 1'b1, 0);
    wait_obs(base + 5, "rst_hold_pre");
    out_ready = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!out_valid && guard < 20);
    n_checks++;
    if (s_addr !== 3'd5 || out_data !== 8'd6) begin
      n_fail++; $display("FAIL rst_hold_k5: addr=%0d od=%0d required 5 6", s_addr, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin n_fail++; $display("FAIL rst_hold_data[%0d]: got %0d required %0d", i, obs_q[base+i], ex); end
    end
    exp_q.delete();
    @(posedge clk); #1 nrst = 1'b0; #1;
    n_checks++;
    if ({out_valid, out_data, done, err, sort_cycles, s_start, s_wr, s_addr, s_datain, busy} !== '0) begin
      n_fail++; $display("FAIL rst_hold_values: ov=%b od=%0d sc=%0d busy=%b required all 0", out_valid, out_data, sort_cycles, busy);
    end
    repeat (2) @(posedge clk); #1 nrst = 1'b1; out_ready = 1'b1;
    base = obs_q.size(); ov0 = n_ov;
    repeat (30) @(posedge clk);
    n_checks++;
    if (obs_q.size() != base || n_ov != ov0) begin
      n_fail++; $display("FAIL rst_hold_no_output: outputs %0d valid cycles %0d required 0", obs_q.size() - base, n_ov - ov0);
    end
    load_job(d7, e7, 1'b1, 2);
    wait_obs(base + 8, "rst_hold_fresh");
    for (int i = 0; i < 8; i++) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q[base+i] !== ex) begin n_fail++; $display("FAIL rst_hold_fresh[%0d]: got %0d required %0d", i, obs_q[base+i], ex); end
    end
  endtask

  initial begin
    test_reset();
    test_sorted_basic();
    test_gaps_dups();
    test_backpressure();
    test_timeout();
    test_reset_mid_job();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
